// File: rtl/regfile_pkg.sv
// Shared types and default widths for the parametrised register file.
package regfile_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: after reset, sweeps every entry to zero one per cycle, then goes READY.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // State register; the terminal compare advances to READY before ptr wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RF_CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RF_READY;
                end
            end
            RF_READY: begin
                state_d = RF_READY;
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

    assign busy     = (state_q == RF_CLEAR);
    assign clr_we   = (state_q == RF_CLEAR) && !rst;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_param.sv
// Three-read / one-write register file with optional bypass, optional zero R0, and hardware clear.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = RF_DATA_W,
    parameter int unsigned ADDR_W  = RF_ADDR_W,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    reg [DATA_W-1:0] mem [0:DEPTH-1];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok_c;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A user write lands only in READY, outside reset, and never into a hard-wired R0.
    assign wr_ok_c = we && !busy && !rst && !(ZERO_R0 && (wa == '0));

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok_c) begin
            mem[wa] <= wd;
        end
    end

    function automatic logic [DATA_W-1:0] rd_mux(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              busy_i,
        input logic              wr_ok,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] res;
        res = stored;
        if (busy_i) begin
            res = '0;
        end else if (ZERO_R0 && (ra == '0)) begin
            res = '0;
        end else if (BYPASS && wr_ok && (ra == waddr)) begin
            res = wdata;
        end
        return res;
    endfunction

    assign rd1 = rd_mux(ra1, mem[ra1], busy, wr_ok_c, wa, wd);
    assign rd2 = rd_mux(ra2, mem[ra2], busy, wr_ok_c, wa, wd);
    assign rd3 = rd_mux(ra3, mem[ra3], busy, wr_ok_c, wa, wd);

endmodule
